pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register. It is the successor to the fixed IF/ID/EX/MEM/WB boundary registers in the RV32 pipelined core. It carries an instruction word, a payload bus and a register-write enable across one stage boundary, with a valid/ready handshake, synchronous flush and bubble (NOP) insertion. An optional 2-entry skid buffer gives a fully registered `in_ready`, and saturating stall/flush counters support performance debug.

---
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline boundary register with flush, bubble insertion,
// optional 2-entry skid buffer and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 SKID      = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_regwen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_regwen,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] main_instr_reg, skid_instr_reg;
    logic [DATA_W-1:0]  main_data_reg, skid_data_reg;
    logic               main_regwen_reg, skid_regwen_reg;
    logic               in_ready_reg;
    logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid_in;

    assign out_valid = (state_reg != EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_reg : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    // Without a skid entry an accepted input always replaces main.
                    if (in_fire && (out_fire || SKID == 0)) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_next   = TWO;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= EMPTY;
            in_ready_reg    <= 1'b1;
            main_instr_reg  <= '0;
            main_data_reg   <= '0;
            main_regwen_reg <= 1'b0;
            skid_instr_reg  <= '0;
            skid_data_reg   <= '0;
            skid_regwen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != TWO);
            if (load_main_in) begin
                main_instr_reg  <= in_instr;
                main_data_reg   <= in_data;
                main_regwen_reg <= in_regwen;
            end else if (load_main_skid) begin
                main_instr_reg  <= skid_instr_reg;
                main_data_reg   <= skid_data_reg;
                main_regwen_reg <= skid_regwen_reg;
            end
            if (load_skid_in) begin
                skid_instr_reg  <= in_instr;
                skid_data_reg   <= in_data;
                skid_regwen_reg <= in_regwen;
            end
        end
    end

    // Counters saturate at all-ones and clear only on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush && out_valid && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign out_instr  = out_valid ? main_instr_reg : NOP_INSTR;
    assign out_regwen = out_valid && main_regwen_reg;
    assign out_data   = main_data_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign flush_cnt  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid (SKID=1) and a single-entry (SKID=0) stage share
// one stimulus stream; each is compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_regwen, out_ready;
    logic [31:0] in_instr, in_data;

    logic        s_in_ready, s_out_valid, s_out_regwen;
    logic [31:0] s_out_instr, s_out_data;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic        n_in_ready, n_out_valid, n_out_regwen;
    logic [31:0] n_out_instr, n_out_data;
    logic [3:0]  n_stall_cnt, n_flush_cnt;

    int n_tests = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .INSTR_W(32), .SKID(1), .NOP_INSTR(NOP), .CNT_W(4)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
        .in_data(in_data), .in_regwen(in_regwen),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_data(s_out_data), .out_regwen(s_out_regwen),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .INSTR_W(32), .SKID(0), .NOP_INSTR(NOP), .CNT_W(4)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
        .in_data(in_data), .in_regwen(in_regwen),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
        .out_data(n_out_data), .out_regwen(n_out_regwen),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    // {valid, instr, regwen, data, in_ready, stall_cnt, flush_cnt}
    logic [74:0] act1, act0;
    assign act1 = {s_out_valid, s_out_instr, s_out_regwen, s_out_data, s_in_ready, s_stall_cnt, s_flush_cnt};
    assign act0 = {n_out_valid, n_out_instr, n_out_regwen, n_out_data, n_in_ready, n_stall_cnt, n_flush_cnt};

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic        regwen;
    } ent_t;

    ent_t        q1[$], q0[$];
    logic [31:0] last1 = '0, last0 = '0;
    int          st1 = 0, fl1 = 0, st0 = 0, fl0 = 0;

    function automatic logic [74:0] exp1();
        ent_t f = (q1.size() > 0) ? q1[0] : '0;
        logic v = (q1.size() > 0);
        logic [3:0] s = 4'(st1);
        logic [3:0] fc = 4'(fl1);
        return {v, v ? f.instr : NOP, v & f.regwen, last1, logic'(q1.size() < 2), s, fc};
    endfunction

    function automatic logic [74:0] exp0();
        ent_t f = (q0.size() > 0) ? q0[0] : '0;
        logic v = (q0.size() > 0);
        logic [3:0] s = 4'(st0);
        logic [3:0] fc = 4'(fl0);
        return {v, v ? f.instr : NOP, v & f.regwen, last0, logic'(!v || out_ready), s, fc};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_data   = $urandom;
        in_regwen = 1'($urandom_range(0, 1));
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance one clock edge, updating both reference models from the applied inputs.
    task automatic step();
        ent_t e;
        bit   i1, o1, i0, o0;
        e  = '{in_instr, in_data, in_regwen};
        i1 = in_valid && (q1.size() < 2);
        o1 = (q1.size() > 0) && out_ready;
        i0 = in_valid && ((q0.size() == 0) || out_ready);
        o0 = (q0.size() > 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            q1.delete(); q0.delete();
            st1 = 0; fl1 = 0; st0 = 0; fl0 = 0;
            last1 = '0; last0 = '0;
        end else begin
            if (q1.size() > 0 && !out_ready && st1 < 15) st1++;
            if (q0.size() > 0 && !out_ready && st0 < 15) st0++;
            if (flush && q1.size() > 0 && fl1 < 15) fl1++;
            if (flush && q0.size() > 0 && fl0 < 15) fl0++;
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                if (o1) void'(q1.pop_front());
                if (i1) q1.push_back(e);
                if (o0) void'(q0.pop_front());
                if (i0) q0.push_back(e);
            end
            if (q1.size() > 0) last1 = q1[0].data;
            if (q0.size() > 0) last0 = q0[0].data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(); step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (act1 !== {1'b0, NOP, 1'b0, 32'h0, 1'b1, 4'h0, 4'h0}) begin
            n_failed++;
            $display("FAIL reset_skid got=%h exp=%h", act1, {1'b0, NOP, 1'b0, 32'h0, 1'b1, 4'h0, 4'h0});
        end
        n_tests++;
        if (act0 !== exp0()) begin
            n_failed++;
            $display("FAIL reset_noskid got=%h exp=%h", act0, exp0());
        end
    endtask

    task automatic test_streaming();
        logic [31:0] instrs [4] = '{32'h00A0_0093, 32'h00B0_0113, 32'h00C0_0193, 32'h00D0_0213};
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, (i < 4) ? instrs[i % 4] : 32'h0, 1'b1, 1'b0);
            step();
            n_tests++;
            if (act1 !== exp1() || (i < 4 && s_out_instr !== instrs[i % 4]) || s_in_ready !== 1'b1) begin
                n_failed++;
                $display("FAIL stream_skid cyc%0d got=%h exp=%h", i, act1, exp1());
            end
            n_tests++;
            if (act0 !== exp0()) begin
                n_failed++;
                $display("FAIL stream_noskid cyc%0d got=%h exp=%h", i, act0, exp0());
            end
        end
    endtask

    task automatic test_backpressure();
        // A, B, three holds, then drain
        logic [31:0] instrs [7] = '{32'hA, 32'hB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive(i < 2, instrs[i], i >= 5, 1'b0);
            step();
            n_tests++;
            if (act1 !== exp1()) begin
                n_failed++;
                $display("FAIL backpressure_skid cyc%0d got=%h exp=%h", i, act1, exp1());
            end
            n_tests++;
            if (act0 !== exp0()) begin
                n_failed++;
                $display("FAIL backpressure_noskid cyc%0d got=%h exp=%h", i, act0, exp0());
            end
        end
    endtask

    task automatic test_flush_two();
        drive(1'b1, 32'hA1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hB2, 1'b0, 1'b0); step();
        drive(1'b1, 32'hC3, 1'b0, 1'b1); step();
        n_tests++;
        if (s_out_valid !== 1'b0 || s_out_instr !== NOP || s_out_regwen !== 1'b0
            || s_in_ready !== 1'b1 || s_flush_cnt !== 4'(fl1) || act1 !== exp1()) begin
            n_failed++;
            $display("FAIL flush_two got=%h exp=%h", act1, exp1());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
            n_tests++;
            if (act1 !== exp1() || act0 !== exp0()) begin
                n_failed++;
                $display("FAIL flush_after cyc%0d got=%h/%h exp=%h/%h", i, act1, act0, exp1(), exp0());
            end
        end
    endtask

    task automatic test_noskid();
        drive(1'b1, 32'h1111, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2222, 1'b0, 1'b0);
        #1;
        n_tests++;
        if (n_in_ready !== 1'b0) begin
            n_failed++;
            $display("FAIL noskid_ready_low got=%b exp=0", n_in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (n_in_ready !== 1'b1) begin
            n_failed++;
            $display("FAIL noskid_ready_follow got=%b exp=1", n_in_ready);
        end
        step();
        n_tests++;
        if (act0 !== exp0() || n_out_instr !== 32'h2222) begin
            n_failed++;
            $display("FAIL noskid_replace got=%h exp=%h", act0, exp0());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0); step(); step();
        n_tests++;
        if (act0 !== exp0() || act1 !== exp1()) begin
            n_failed++;
            $display("FAIL noskid_drain got=%h/%h exp=%h/%h", act0, act1, exp0(), exp1());
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 32'h5A, 1'b0, 1'b0); step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            step();
            n_tests++;
            if (act1 !== exp1() || act0 !== exp0()) begin
                n_failed++;
                $display("FAIL stall_sat cyc%0d got=%h/%h exp=%h/%h", i, act1, act0, exp1(), exp0());
            end
        end
        n_tests++;
        if (s_stall_cnt !== 4'hF || n_stall_cnt !== 4'hF) begin
            n_failed++;
            $display("FAIL stall_sat_final got=%h/%h exp=f", s_stall_cnt, n_stall_cnt);
        end
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h100 + i, 1'b0, 1'b0); step();
            drive(1'b0, 32'h0, 1'b0, 1'b1); step();
            n_tests++;
            if (act1 !== exp1() || act0 !== exp0()) begin
                n_failed++;
                $display("FAIL flush_sat cyc%0d got=%h/%h exp=%h/%h", i, act1, act0, exp1(), exp0());
            end
        end
        n_tests++;
        if (s_flush_cnt !== 4'hF || n_flush_cnt !== 4'hF) begin
            n_failed++;
            $display("FAIL flush_sat_final got=%h/%h exp=f", s_flush_cnt, n_flush_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h77, 1'b0, 1'b0); step();
        drive(1'b1, 32'h88, 1'b0, 1'b0); step();
        reset = 1'b1;
        drive(1'b1, 32'h99, 1'b1, 1'b1); step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (act1 !== {1'b0, NOP, 1'b0, 32'h0, 1'b1, 4'h0, 4'h0} || act0 !== exp0()) begin
            n_failed++;
            $display("FAIL reset_mid got=%h/%h exp=%h/%h", act1, act0, exp1(), exp0());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (act1 !== exp1() || act0 !== exp0()) begin
                n_failed++;
                $display("FAIL reset_mid_after cyc%0d got=%h/%h exp=%h/%h", i, act1, act0, exp1(), exp0());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
            step();
            n_tests++;
            if (act1 !== exp1()) begin
                n_failed++;
                $display("FAIL random_skid cyc%0d got=%h exp=%h", i, act1, exp1());
            end
            n_tests++;
            if (act0 !== exp0()) begin
                n_failed++;
                $display("FAIL random_noskid cyc%0d got=%h exp=%h", i, act0, exp0());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_noskid();
        test_saturation();
        reset = 1'b1; drive(1'b0, 32'h0, 1'b1, 1'b0); step(); reset = 1'b0;
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
